// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: address map, select indices, FSM states and owner encoding for the memory bus arbiter
package mem_bus_arbiter_pkg;

    localparam logic [31:0] IMEM_BASE  = 32'h0000_0000;
    localparam logic [31:0] IMEM_LIMIT = 32'h0000_3FFF;
    localparam logic [31:0] DMEM_BASE  = 32'h0000_4000;
    localparam logic [31:0] DMEM_LIMIT = 32'h0000_6FFF;
    localparam logic [31:0] UART_BASE  = 32'h8000_0000;
    localparam logic [31:0] UART_LIMIT = 32'h8000_000F;
    localparam logic [31:0] GPIO_BASE  = 32'h8000_0010;
    localparam logic [31:0] GPIO_LIMIT = 32'h8000_001F;

    localparam int SEL_IMEM = 0;
    localparam int SEL_DMEM = 1;
    localparam int SEL_UART = 2;
    localparam int SEL_GPIO = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    typedef enum logic {OWN_M0, OWN_M1} owner_e;

    function automatic logic in_range(logic [31:0] a, logic [31:0] lo, logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch (m0), load/store (m1) and slave-side signals of the shared memory bus
//   master modport: the arbiter view (drives gnt/rvalid/rdata/err and the s_* access)
//   slave modport : the environment view (cores and memory-mapped slaves)
interface mem_bus_arbiter_if #(parameter int DATA_W = 32);
    logic              m0_req;
    logic [31:0]       m0_addr;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;
    logic              m1_req;
    logic [31:0]       m1_addr;
    logic              m1_we;
    logic [DATA_W/8-1:0] m1_be;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;
    logic              s_req;
    logic [3:0]        s_sel;
    logic [31:0]       s_addr;
    logic              s_we;
    logic [DATA_W/8-1:0] s_be;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata;
    logic              s_ready;

    modport master (
        input  m0_req, m0_addr, m1_req, m1_addr, m1_we, m1_be, m1_wdata, s_rdata, s_ready,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
               s_req, s_sel, s_addr, s_we, s_be, s_wdata
    );

    modport slave (
        output m0_req, m0_addr, m1_req, m1_addr, m1_we, m1_be, m1_wdata, s_rdata, s_ready,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
               s_req, s_sel, s_addr, s_we, s_be, s_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter_bus_region_decode.sv
// bus_region_decode: combinational address to one-hot region hit {gpio,uart,dmem,imem}
//   addr_i : 32-bit byte address
//   hit_o  : one-hot region hit, all zero when unmapped
module bus_region_decode
    import mem_bus_arbiter_pkg::*;
(
    input  logic [31:0] addr_i,
    output logic [3:0]  hit_o
);
    assign hit_o[SEL_IMEM] = in_range(addr_i, IMEM_BASE, IMEM_LIMIT);
    assign hit_o[SEL_DMEM] = in_range(addr_i, DMEM_BASE, DMEM_LIMIT);
    assign hit_o[SEL_UART] = in_range(addr_i, UART_BASE, UART_LIMIT);
    assign hit_o[SEL_GPIO] = in_range(addr_i, GPIO_BASE, GPIO_LIMIT);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between fetch (m0) and load/store (m1), one transfer at a time
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : master modport carrying both requester ports and the slave access port
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_bus_arbiter_if.master    bus
);
    localparam int BE_W = DATA_W / 8;

    state_e              state_q;
    owner_e              own_q;
    owner_e              last_q;
    logic [31:0]         addr_q;
    logic                we_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          sel_q;
    logic                ill_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                s_req_q;
    logic                rv0_q;
    logic                rv1_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    owner_e              pick;
    logic [31:0]         addr_d;
    logic                we_d;
    logic [BE_W-1:0]     be_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [3:0]          hit;
    logic                illegal;
    logic                grant;
    logic                timeout;
    logic                done;

    // On a tie the master that did not own the bus last wins.
    assign pick    = (bus.m0_req && (!bus.m1_req || last_q == OWN_M1)) ? OWN_M0 : OWN_M1;
    assign addr_d  = (pick == OWN_M0) ? bus.m0_addr : bus.m1_addr;
    assign we_d    = (pick == OWN_M1) && bus.m1_we;
    assign be_d    = (pick == OWN_M1) ? bus.m1_be : '1;
    assign wdata_d = (pick == OWN_M1) ? bus.m1_wdata : '0;

    bus_region_decode u_decode (
        .addr_i (addr_d),
        .hit_o  (hit)
    );

    assign illegal = (hit == 4'b0000) || (addr_d[1:0] != 2'b00) ||
                     (we_d && hit[SEL_IMEM]) || (be_d == '0);

    // Gated with rst_n so no grant leaks out while reset is held.
    assign grant = rst_n && (state_q == IDLE) && (bus.m0_req || bus.m1_req);
    assign bus.m0_gnt = grant && (pick == OWN_M0);
    assign bus.m1_gnt = grant && (pick == OWN_M1);

    assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign done    = ill_q || bus.s_ready || timeout;

    assign bus.s_req     = s_req_q;
    assign bus.s_sel     = sel_q;
    assign bus.s_addr    = addr_q;
    assign bus.s_we      = we_q;
    assign bus.s_be      = be_q;
    assign bus.s_wdata   = wdata_q;
    assign bus.m0_rvalid = rv0_q;
    assign bus.m1_rvalid = rv1_q;
    assign bus.m0_rdata  = rv0_q ? rdata_q : '0;
    assign bus.m1_rdata  = rv1_q ? rdata_q : '0;
    assign bus.m0_err    = rv0_q && err_q;
    assign bus.m1_err    = rv1_q && err_q;

    // Illegal transfers still pass through ACCESS, but with s_req held low, so every
    // response lands two cycles after its grant and grants stay three cycles apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            own_q   <= OWN_M1;
            last_q  <= OWN_M1;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
            s_req_q <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        own_q   <= pick;
                        last_q  <= pick;
                        addr_q  <= addr_d;
                        we_q    <= we_d;
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        sel_q   <= illegal ? 4'b0000 : hit;
                        ill_q   <= illegal;
                        s_req_q <= !illegal;
                        cnt_q   <= '0;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (done) begin
                        s_req_q <= 1'b0;
                        rv0_q   <= (own_q == OWN_M0);
                        rv1_q   <= (own_q == OWN_M1);
                        err_q   <= ill_q || !bus.s_ready;
                        rdata_q <= (ill_q || !bus.s_ready || we_q) ? '0 : bus.s_rdata;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    rv0_q   <= 1'b0;
                    rv1_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
